// File: rtl/digital_clock_pkg.sv
// Shared constants and BCD helpers for the display-counting channels.
package digital_clock_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    localparam int unsigned BTN_NEXT   = 0;
    localparam int unsigned BTN_INC    = 1;
    localparam int unsigned BTN_DEC    = 2;
    localparam int unsigned BTN_COMMIT = 3;

    // Packed 8-digit BCD to binary.
    function automatic int unsigned bcd_to_bin(input logic [31:0] b);
        int unsigned t;
        t = 0;
        for (int i = 7; i >= 0; i--) begin
            t = t * 10 + 32'(b[4*i +: 4]);
        end
        return t;
    endfunction

    // Binary to packed 8-digit BCD, digit 0 in bits [3:0].
    function automatic logic [31:0] bin_to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_timer_n_button_conditioner.sv
// Push-button conditioner: 2-FF sync, stability debounce, one pulse per accepted press.
module button_conditioner #(
    parameter int unsigned DEBOUNCE = 270000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          pressed_c;

    assign pressed_c = ~sync_q[1];

    // After reset a button reads as held until it has been seen released,
    // so a button held through reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            pulse    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            pulse  <= 1'b0;
            if (pressed_c == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
                cnt_q    <= '0;
                stable_q <= pressed_c;
                pulse    <= pressed_c;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_timer_n.sv
// N-digit BCD up/down timer with prescaler, wrap/saturate, per-digit edit and sticky TC LED.
module bcd_timer_n
    import digital_clock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned MAX_VALUE  = 999,
    parameter int unsigned TICK_DIV   = 27000000,
    parameter int unsigned FLASH_DIV  = 13500000,
    parameter int unsigned DEBOUNCE   = 270000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      count_up,
    input  logic                      load,
    input  logic                      edit,
    input  logic                      wrap_en,
    input  logic [3:0]                buttons,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [4*NUM_DIGITS-1:0]   disp_digits,
    output logic                      tc_led,
    output logic [2:0]                sel_digit
);

    localparam int unsigned W  = BCD_W * NUM_DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned FW = $clog2(FLASH_DIV);
    localparam logic [W-1:0] MAX_BCD = W'(bin_to_bcd(MAX_VALUE));

    logic [W-1:0]  count_q, shadow_q, disp_q;
    logic          tc_q, phase_q, edit_q;
    logic [2:0]    sel_q;
    logic [PW-1:0] presc_q;
    logic [FW-1:0] flash_q;
    logic [3:0]    pulse;

    logic [W-1:0]  inc_c, dec_c, shadow_edit_c, disp_edit_c, commit_val_c;
    logic [NUM_DIGITS-1:0] carry, borrow;
    logic          edit_rise_c, commit_c, tick_c;
    logic [2:0]    sel_next_c;
    logic [3:0]    sd;

    for (genvar b = 0; b < 4; b++) begin : g_btn
        button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw   (buttons[b]),
            .pulse (pulse[b])
        );
    end

    // Single-cycle BCD increment/decrement ripple across all digits.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_bcd
        logic [3:0] d;
        assign d = count_q[BCD_W*g +: BCD_W];
        assign inc_c[BCD_W*g +: BCD_W] = carry[g]  ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
        assign dec_c[BCD_W*g +: BCD_W] = borrow[g] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
        if (g < NUM_DIGITS - 1) begin : g_chain
            assign carry[g+1]  = carry[g]  & (d == 4'd9);
            assign borrow[g+1] = borrow[g] & (d == 4'd0);
        end
    end

    assign edit_rise_c  = edit & ~edit_q;
    assign commit_c     = edit & (load | pulse[BTN_COMMIT]);
    assign tick_c       = ~edit & (presc_q == PW'(TICK_DIV - 1));
    assign sel_next_c   = (sel_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : sel_q + 3'd1;
    // Valid BCD orders the same as binary, so the clamp compares BCD directly.
    assign commit_val_c = (shadow_q > MAX_BCD) ? MAX_BCD : shadow_q;

    // Selected-digit edit of the shadow and flashed display image.
    always_comb begin
        shadow_edit_c = shadow_q;
        disp_edit_c   = shadow_q;
        sd            = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) == sel_q) begin
                sd = shadow_q[BCD_W*i +: BCD_W];
                if (pulse[BTN_INC]) begin
                    sd = (sd == 4'd9) ? 4'd0 : sd + 4'd1;
                end else if (pulse[BTN_DEC]) begin
                    sd = (sd == 4'd0) ? 4'd9 : sd - 4'd1;
                end
                shadow_edit_c[BCD_W*i +: BCD_W] = sd;
                if (!phase_q) begin
                    disp_edit_c[BCD_W*i +: BCD_W] = BLANK_CODE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            tc_q     <= 1'b0;
            sel_q    <= 3'd0;
            presc_q  <= '0;
            flash_q  <= '0;
            phase_q  <= 1'b0;
            edit_q   <= 1'b0;
        end else begin
            edit_q <= edit;
            disp_q <= edit_q ? disp_edit_c : count_q;

            if (edit || commit_c || tick_c) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end

            if (edit_rise_c || (|pulse)) begin
                flash_q <= '0;
                phase_q <= 1'b1;
            end else if (flash_q == FW'(FLASH_DIV - 1)) begin
                flash_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                flash_q <= flash_q + FW'(1);
            end

            if (commit_c) begin
                count_q <= commit_val_c;
                tc_q    <= 1'b0;
            end else if (edit_rise_c) begin
                shadow_q <= count_q;
                sel_q    <= 3'd0;
            end else if (edit) begin
                if (pulse[BTN_NEXT]) begin
                    sel_q <= sel_next_c;
                end
                shadow_q <= shadow_edit_c;
            end else if (tick_c && enable) begin
                if (count_up) begin
                    if (count_q == MAX_BCD) begin
                        count_q <= wrap_en ? '0 : MAX_BCD;
                        tc_q    <= 1'b1;
                    end else begin
                        count_q <= inc_c;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_q <= wrap_en ? MAX_BCD : '0;
                        tc_q    <= 1'b1;
                    end else begin
                        count_q <= dec_c;
                    end
                end
            end
        end
    end

    assign digits      = count_q;
    assign disp_digits = disp_q;
    assign tc_led      = tc_q;
    assign sel_digit   = sel_q;

endmodule

// File: tb/tb_bcd_timer_n.sv
// Self-checking bench for bcd_timer_n against an integer-valued behavioural model.
module tb_bcd_timer_n;

    localparam int unsigned ND   = 3;
    localparam int unsigned MAXV = 125;
    localparam int unsigned TD   = 4;
    localparam int unsigned FD   = 8;
    localparam int unsigned DB   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, count_up = 1'b1, load = 1'b0;
    logic        edit = 1'b0, wrap_en = 1'b1;
    logic [3:0]  buttons = 4'hF;
    logic [11:0] digits, disp_digits;
    logic        tc_led;
    logic [2:0]  sel_digit;

    bcd_timer_n #(
        .NUM_DIGITS(ND), .MAX_VALUE(MAXV), .TICK_DIV(TD), .FLASH_DIV(FD), .DEBOUNCE(DB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .count_up(count_up), .load(load),
        .edit(edit), .wrap_en(wrap_en), .buttons(buttons), .digits(digits),
        .disp_digits(disp_digits), .tc_led(tc_led), .sel_digit(sel_digit)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          m_count, m_sel, m_mp;
    int          m_sh [3];
    bit          m_tc, m_edit_q, m_disp_known;
    logic [11:0] m_disp_exp;
    logic [3:0]  smp [44];
    logic [3:0]  fexp;
    int          t0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_commit();
        int v;
        v = m_sh[0] + 10 * m_sh[1] + 100 * m_sh[2];
        m_count = (v > int'(MAXV)) ? int'(MAXV) : v;
        m_tc = 1'b0;
        m_mp = 0;
    endtask

    // Apply the current inputs to the model for the coming clock edge.
    task automatic model_edge();
        if (reset) begin
            m_disp_exp = '0; m_disp_known = 1'b1;
            m_count = 0; m_sh = '{0, 0, 0}; m_sel = 0; m_tc = 1'b0; m_mp = 0; m_edit_q = 1'b0;
        end else begin
            m_disp_known = !m_edit_q;
            m_disp_exp   = to_bcd(m_count);
            if (edit && load) begin
                do_commit();
            end else if (edit) begin
                m_mp = 0;
                if (!m_edit_q) begin
                    m_sh[0] = m_count % 10; m_sh[1] = (m_count / 10) % 10; m_sh[2] = m_count / 100;
                    m_sel = 0;
                end
            end else if (m_mp == int'(TD) - 1) begin
                m_mp = 0;
                if (enable) begin
                    if (count_up) begin
                        if (m_count == int'(MAXV)) begin
                            m_count = wrap_en ? 0 : int'(MAXV); m_tc = 1'b1;
                        end else m_count++;
                    end else begin
                        if (m_count == 0) begin
                            m_count = wrap_en ? int'(MAXV) : 0; m_tc = 1'b1;
                        end else m_count--;
                    end
                end
            end else begin
                m_mp++;
            end
            m_edit_q = edit;
        end
    endtask

    task automatic step(input bit chk_en);
        model_edge();
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("digits", 32'(digits), 32'(to_bcd(m_count)));
            chk("tc_led", 32'(tc_led), 32'(m_tc));
            chk("sel_digit", 32'(sel_digit), 32'(m_sel));
            if (m_disp_known) chk("disp_digits", 32'(disp_digits), 32'(m_disp_exp));
        end
    endtask

    // Full press and release; the model takes the action once the button is back up.
    task automatic press(input int i);
        buttons[i] = 1'b0;
        repeat (DB + 6) step(1'b0);
        buttons[i] = 1'b1;
        repeat (DB + 6) step(1'b0);
        if (m_edit_q) begin
            case (i)
                0: m_sel = (m_sel + 1) % int'(ND);
                1: m_sh[m_sel] = (m_sh[m_sel] + 1) % 10;
                2: m_sh[m_sel] = (m_sh[m_sel] + 9) % 10;
                default: do_commit();
            endcase
        end
    endtask

    task automatic check_edit_disp();
        logic [3:0] d;
        for (int i = 0; i < int'(ND); i++) begin
            d = disp_digits[4*i +: 4];
            if (i != m_sel) chk("disp_other", 32'(d), 32'(m_sh[i]));
            else chk("disp_sel", 32'((d === 4'(m_sh[i])) || (d === 4'hF)), 32'd1);
        end
    endtask

    task automatic set_value(input int v);
        int pw [3];
        int tgt, diff;
        pw = '{1, 10, 100};
        edit = 1'b1;
        step(1'b0);
        for (int d = 0; d < 3; d++) begin
            tgt  = (v / pw[d]) % 10;
            diff = (tgt - m_sh[d] + 10) % 10;
            if (diff <= 5) repeat (diff) press(1);
            else repeat (10 - diff) press(2);
            press(0);
        end
        load = 1'b1;
        step(1'b0);
        load = 1'b0;
        edit = 1'b0;
        step(1'b1);
    endtask

    initial begin
        // 1: wrap-up count through the terminal value
        step(1'b1);
        reset = 1'b0; enable = 1'b1; count_up = 1'b1; wrap_en = 1'b1;
        for (int k = 1; k <= 520; k++) begin
            step(1'b1);
            if (k == 500) begin
                chk("t1_at_max", 32'(digits), 32'h125);
                chk("t1_tc_before", 32'(tc_led), 32'd0);
            end
            if (k == 504) begin
                chk("t1_wrapped", 32'(digits), 32'h000);
                chk("t1_tc_after", 32'(tc_led), 32'd1);
            end
            if (k == 520) chk("t1_tick130", 32'(digits), 32'h004);
        end

        // 2: saturate at zero going down, then wrap to MAX
        reset = 1'b1; step(1'b1); reset = 1'b0;
        count_up = 1'b0; wrap_en = 1'b0;
        repeat (12) step(1'b1);
        chk("t2_sat_zero", 32'(digits), 32'h000);
        chk("t2_tc", 32'(tc_led), 32'd1);
        wrap_en = 1'b1;
        repeat (4) step(1'b1);
        chk("t2_wrap_down", 32'(digits), 32'h125);

        // 3: edit to 142, commit clamps to 125, glitch ignored
        set_value(42);
        chk("t3_loaded", 32'(digits), 32'h042);
        edit = 1'b1; step(1'b1);
        press(0); press(0); press(1);
        step(1'b1);
        chk("t3_sel", 32'(sel_digit), 32'd2);
        check_edit_disp();
        press(3);
        step(1'b1);
        chk("t3_clamped", 32'(digits), 32'h125);
        chk("t3_tc_clear", 32'(tc_led), 32'd0);
        buttons[1] = 1'b0; step(1'b0); buttons[1] = 1'b1;
        repeat (DB + 6) step(1'b0);
        press(0);
        step(1'b1);
        check_edit_disp();
        chk("t3_glitch", 32'(disp_digits[11:4]), 32'h14);
        edit = 1'b0; step(1'b1);

        // 4: flashing of the selected digit
        edit = 1'b1; step(1'b1);
        press(0);
        for (int c = 0; c < 44; c++) begin
            step(1'b1);
            smp[c] = disp_digits[7:4];
            chk("t4_d0", 32'(disp_digits[3:0]), 32'(m_sh[0]));
            chk("t4_d2", 32'(disp_digits[11:8]), 32'(m_sh[2]));
        end
        t0 = -1;
        for (int c = 1; c <= 9; c++) if (t0 < 0 && smp[c] !== smp[c-1]) t0 = c;
        chk("t4_flash_edge", 32'(t0 > 0), 32'd1);
        if (t0 > 0) begin
            chk("t4_flash_codes", 32'((smp[t0] === 4'hF && smp[t0-1] === 4'(m_sh[1])) ||
                                      (smp[t0] === 4'(m_sh[1]) && smp[t0-1] === 4'hF)), 32'd1);
            for (int c = t0; c < t0 + 32; c++) begin
                fexp = (((c - t0) / int'(FD)) % 2 == 0) ? smp[t0] : smp[t0-1];
                chk("t4_flash_phase", 32'(smp[c]), 32'(fexp));
            end
        end
        edit = 1'b0; step(1'b1);

        // 5: leaving edit without commit discards the shadow
        count_up = 1'b1; enable = 1'b1;
        set_value(99);
        step(1'b1);
        edit = 1'b1; step(1'b1);
        press(1);
        step(1'b1);
        check_edit_disp();
        chk("t5_shadow", 32'(disp_digits[11:4]), 32'h09);
        edit = 1'b0; step(1'b1);
        chk("t5_unchanged", 32'(digits), 32'h099);
        repeat (8) step(1'b1);
        chk("t5_resumed", 32'(digits), 32'h101);

        // 6: reset mid-edit with a held button; no pulse until re-press
        edit = 1'b1; step(1'b1);
        buttons[1] = 1'b0;
        repeat (DB + 6) step(1'b0);
        m_sh[m_sel] = (m_sh[m_sel] + 1) % 10;
        reset = 1'b1; step(1'b1);
        chk("t6_digits", 32'(digits), 32'd0);
        chk("t6_disp", 32'(disp_digits), 32'd0);
        chk("t6_tc", 32'(tc_led), 32'd0);
        chk("t6_sel", 32'(sel_digit), 32'd0);
        reset = 1'b0;
        repeat (10) step(1'b1);
        buttons[1] = 1'b1;
        repeat (DB + 6) step(1'b0);
        press(0); step(1'b1);
        check_edit_disp();
        press(0); press(0); press(1); press(0); step(1'b1);
        check_edit_disp();
        chk("t6_repress", 32'(disp_digits[3:0]), 32'd1);
        edit = 1'b0; step(1'b1);

        // Randomised segments against the model
        for (int s = 0; s < 8; s++) begin
            case ($urandom_range(0, 3))
                0: set_value(int'($urandom_range(0, 999)));
                1: set_value(int'(MAXV) - 1);
                2: set_value(1);
                default: ;
            endcase
            count_up = 1'($urandom_range(0, 1));
            wrap_en  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 40; k++) begin
                enable = ($urandom_range(0, 7) != 0);
                load   = ($urandom_range(0, 7) == 0);
                step(1'b1);
            end
            load = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_timer_n.md
Name: bcd_timer_n

Overview:
Parametrised N-digit BCD up/down timer that generalises the fixed count_59/count_999 channels. It is the next-generation counting channel feeding the mux/seg7 display path. It adds:
- configurable digit count and terminal value
- wrap or saturate mode
- internal prescaler
- conditioned push-buttons
- per-digit edit mode with a flashing selected digit
- sticky terminal-count LED

Parameters:
NUM_DIGITS, 3, number of BCD digits (1..8)
MAX_VALUE, 999, terminal count; must be < 10**NUM_DIGITS
TICK_DIV, 27000000, clk cycles per count tick (>=2)
FLASH_DIV, 13500000, clk cycles per flash phase toggle (>=2)
DEBOUNCE, 270000, cycles a button must be stable before it is accepted (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run counting when 1
count_up  in  1  1=up, 0=down
load  in  1  level; commit edit shadow into count (same as btn3)
edit  in  1  1=edit mode, counting paused
wrap_en  in  1  1=wrap at terminal, 0=saturate
buttons  in  4  raw active-low: [0] next digit, [1] digit+1, [2] digit-1, [3] commit
digits  out  4*NUM_DIGITS  live count, BCD, digit 0 = LSD
disp_digits  out  4*NUM_DIGITS  display bus (shadow in edit, blank code 4'hF on flashed digit)
tc_led  out  1  sticky terminal-count indicator
sel_digit  out  3  currently selected edit digit

Behaviour:
- Reset values: count=0, shadow=0, digits=0, disp_digits=0, tc_led=0, sel_digit=0. Prescaler, flash counter and button conditioners are also cleared.
- Prescaler: counts 0..TICK_DIV-1. tick is asserted for 1 cycle at wrap. It is held at 0 while edit=1 and cleared on commit.
- Count on tick with enable=1 and edit=0:
  - Up: count+1 with BCD carry ripple across all digits in one cycle.
  - At MAX_VALUE going up: wrap_en=1 gives 0; wrap_en=0 holds MAX_VALUE.
  - At 0 going down: wrap_en=1 gives MAX_VALUE; wrap_en=0 holds 0.
  - Any terminal event (wrap or saturate attempt) sets tc_led on the next cycle.
- tc_led clears on reset or commit only.
- Button path, per bit:
  - 2-FF synchroniser, then inversion.
  - Stability counter: the pressed level is accepted after DEBOUNCE stable cycles.
  - Each press produces exactly one 1-cycle pulse. Holding a button gives no repeat.
- Edit entry: on the rising edge of edit, shadow<=count and sel_digit<=0.
- Edit-mode actions:
  - btn0 pulse: sel_digit<=(sel_digit+1) mod NUM_DIGITS.
  - btn1 pulse: shadow[sel] +1 mod 10, no carry.
  - btn2 pulse: shadow[sel] -1 mod 10, no borrow.
- Outside edit mode, btn0/1/2 are ignored.
- Commit (btn3 pulse or load=1 while edit=1):
  - count<=shadow, clamped to MAX_VALUE if greater.
  - tc_led<=0, prescaler<=0.
  - load/btn3 while edit=0: no effect.
- Priority: reset > commit > edit-mode button action > tick. Simultaneous btn1 and btn2 pulses: btn1 wins.
- Flash: phase toggles every FLASH_DIV cycles. Phase resets to 1 (visible) on edit entry and on every button pulse.
- disp_digits:
  - edit=0: equals digits.
  - edit=1: equals shadow, with digit sel replaced by 4'hF while phase=0.
- Latency: digits changes 1 cycle after tick. disp_digits is registered, 1 cycle after its source.
- Leaving edit without commit discards shadow; counting resumes from the unchanged count.
- Mid-operation reset: all state returns to reset values on the next edge, regardless of edit or button state.

Decomposition:
- Shared package digital_clock_pkg:
  - BCD_W=4, BLANK_CODE=4'hF
  - button index constants BTN_NEXT=0, BTN_INC=1, BTN_DEC=2, BTN_COMMIT=3
  - function bcd_to_bin / bin_to_bcd for the MAX_VALUE comparison
- One sub-module, button_conditioner (sync + debounce + press pulse, parameter DEBOUNCE), instantiated 4 times.
- The BCD ripple stays inline as a generate loop.

Test Plan:
Bench parameters: NUM_DIGITS=3, MAX_VALUE=125, TICK_DIV=4, FLASH_DIV=8, DEBOUNCE=2.
1. reset 1 cycle, enable=1, count_up=1, wrap_en=1, 130 ticks -> digits 0,1,...,125, then 0 at tick 126, then 4 at tick 130. tc_led=1 from the cycle after the wrap.
2. count=0, count_up=0, wrap_en=0, 3 ticks -> digits stay 0, tc_led=1. Then wrap_en=1, 1 tick -> digits=125.
3. count=042, edit=1:
   - btn0 twice, btn1 once -> shadow=142, sel_digit=2.
   - btn3 -> digits=125 (clamped), tc_led=0.
   - A 1-cycle glitch on buttons[1] produces no change.
4. edit=1, sel_digit=1, no presses for 32 cycles -> disp_digits[7:4] alternates shadow digit / 4'hF every 8 cycles. Other digits are constant.
5. count=099, edit=1, btn1 on sel 0 -> shadow=090. Deassert edit without commit -> digits=099 and counting resumes.
6. Reset asserted mid-edit with btn1 held -> all outputs 0 next cycle. No pulse is emitted after reset release until the button is released and re-pressed.
